// File: rtl/tracking_adc_mc.sv
// ----------------------------------------------------------------------------
// tracking_adc_mc
//
// Multi-channel tracking (delta-modulation) ADC back end. Each channel turns
// its comparator decision into a saturating up/down accumulator. All channels
// are decimated on one shared window. The result is a packed, channel-aligned
// sample word with a one-cycle valid strobe and per-window range flags.
//
// Build option:
//   TRACKING_ADC_ADAPTIVE_STEP_EN
//     Defined   : step size doubles after RUN_LENGTH consecutive
//                 same-direction cycles, up to 2^MAX_STEP_LOG2 LSB.
//     Undefined : fixed 1 LSB step. RUN_LENGTH and MAX_STEP_LOG2 are unused.
//
// Ports:
//   clk            in   sole clock, rising edge
//   reset          in   asynchronous, active-high reset
//   enable         in   advance qualifier; low holds all state
//   comparator_in  in   [CHANNELS] 1 = step down, 0 = step up
//   out            out  [CHANNELS*RESOLUTION] channel k at [k*RESOLUTION +: RESOLUTION]
//   out_valid      out  one-cycle strobe when out/flags are new
//   underflow      out  [CHANNELS] down step clamped at 0 during window
//   overflow       out  [CHANNELS] up step clamped at full scale during window
// ----------------------------------------------------------------------------
module tracking_adc_mc #(
    parameter int CHANNELS      = 4,
    parameter int RESOLUTION    = 10,
    parameter int MAX_STEP_LOG2 = 3,
    parameter int RUN_LENGTH    = 4,
    parameter int DECIMATION    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [CHANNELS-1:0]            comparator_in,
    output logic [CHANNELS*RESOLUTION-1:0] out,
    output logic                           out_valid,
    output logic [CHANNELS-1:0]            underflow,
    output logic [CHANNELS-1:0]            overflow
);

    localparam int AW    = RESOLUTION + 1;
    localparam int WIN_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic [RESOLUTION-1:0] ACC_MAX  = '1;
    localparam logic [AW-1:0]         FULL     = {1'b0, ACC_MAX};
    localparam logic [RESOLUTION-1:0] MIDSCALE = {1'b1, {(RESOLUTION-1){1'b0}}};

    // Catch illegal configurations at elaboration time.
    if (MAX_STEP_LOG2 >= RESOLUTION - 1 || RUN_LENGTH < 1 || DECIMATION < 1 ||
        CHANNELS < 1 || RESOLUTION < 4) begin : g_param_check
        $error("tracking_adc_mc: illegal parameter combination");
    end

    logic [RESOLUTION-1:0]          acc_q [CHANNELS];
    logic [RESOLUTION-1:0]          acc_d [CHANNELS];
    logic [CHANNELS-1:0]            uf_w_q, uf_w_d, of_w_q, of_w_d;
    logic [CHANNELS-1:0]            clamp_up, clamp_dn;
    logic [WIN_W-1:0]               win_q, win_d;
    logic                           win_end;
    logic [CHANNELS*RESOLUTION-1:0] out_q, out_d;
    logic                           out_valid_q, out_valid_d;
    logic [CHANNELS-1:0]            underflow_q, underflow_d;
    logic [CHANNELS-1:0]            overflow_q, overflow_d;
    logic [AW-1:0]                  step_amt, sum;

`ifdef TRACKING_ADC_ADAPTIVE_STEP_EN
    localparam int STEP_W = (MAX_STEP_LOG2 > 0) ? $clog2(MAX_STEP_LOG2 + 1) : 1;
    localparam int RUN_W  = (RUN_LENGTH > 1) ? $clog2(RUN_LENGTH) : 1;

    logic [STEP_W-1:0]   step_log2_q [CHANNELS];
    logic [STEP_W-1:0]   step_log2_d [CHANNELS];
    logic [RUN_W-1:0]    run_q [CHANNELS];
    logic [RUN_W-1:0]    run_d [CHANNELS];
    logic [CHANNELS-1:0] last_dir_q, last_dir_d;   // 1 = DOWN, 0 = UP
`endif

    always_comb begin
        win_end = enable && (win_q == WIN_W'(DECIMATION - 1));
        win_d   = win_q;
        if (enable) begin
            win_d = win_end ? '0 : win_q + WIN_W'(1);
        end

        clamp_up = '0;
        clamp_dn = '0;
        step_amt = AW'(1);
        sum      = '0;
`ifdef TRACKING_ADC_ADAPTIVE_STEP_EN
        last_dir_d = last_dir_q;
`endif

        for (int i = 0; i < CHANNELS; i++) begin
            acc_d[i] = acc_q[i];
`ifdef TRACKING_ADC_ADAPTIVE_STEP_EN
            step_log2_d[i] = step_log2_q[i];
            run_d[i]       = run_q[i];
            step_amt       = AW'(1) << step_log2_q[i];
            if (enable) begin
                last_dir_d[i] = comparator_in[i];
                if (comparator_in[i] != last_dir_q[i]) begin
                    // Direction reversal: fall back to 1 LSB and restart the run.
                    step_amt = AW'(1);
                    if (RUN_LENGTH == 1) begin
                        run_d[i]       = '0;
                        step_log2_d[i] = (MAX_STEP_LOG2 > 0) ? STEP_W'(1) : '0;
                    end else begin
                        run_d[i]       = RUN_W'(1);
                        step_log2_d[i] = '0;
                    end
                end else if (run_q[i] == RUN_W'(RUN_LENGTH - 1)) begin
                    run_d[i] = '0;
                    if (step_log2_q[i] != STEP_W'(MAX_STEP_LOG2)) begin
                        step_log2_d[i] = step_log2_q[i] + STEP_W'(1);
                    end
                end else begin
                    run_d[i] = run_q[i] + RUN_W'(1);
                end
            end
`else
            step_amt = AW'(1);
`endif
            // Saturating update, evaluated one bit wider so nothing wraps.
            if (enable) begin
                if (comparator_in[i]) begin
                    if ({1'b0, acc_q[i]} < step_amt) begin
                        acc_d[i]    = '0;
                        clamp_dn[i] = 1'b1;
                    end else begin
                        acc_d[i] = acc_q[i] - step_amt[RESOLUTION-1:0];
                    end
                end else begin
                    sum = {1'b0, acc_q[i]} + step_amt;
                    if (sum > FULL) begin
                        acc_d[i]    = ACC_MAX;
                        clamp_up[i] = 1'b1;
                    end else begin
                        acc_d[i] = sum[RESOLUTION-1:0];
                    end
                end
            end
        end

        // Window flags restart clean; the closing cycle's clamps go into the sample.
        uf_w_d      = win_end ? '0 : (uf_w_q | clamp_dn);
        of_w_d      = win_end ? '0 : (of_w_q | clamp_up);
        out_d       = out_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        out_valid_d = win_end;
        if (win_end) begin
            for (int i = 0; i < CHANNELS; i++) begin
                out_d[i*RESOLUTION +: RESOLUTION] = acc_d[i];
            end
            underflow_d = uf_w_q | clamp_dn;
            overflow_d  = of_w_q | clamp_up;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= MIDSCALE;
`ifdef TRACKING_ADC_ADAPTIVE_STEP_EN
                step_log2_q[i] <= '0;
                run_q[i]       <= '0;
`endif
            end
`ifdef TRACKING_ADC_ADAPTIVE_STEP_EN
            last_dir_q <= '0;
`endif
            uf_w_q      <= '0;
            of_w_q      <= '0;
            win_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            underflow_q <= '0;
            overflow_q  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= acc_d[i];
`ifdef TRACKING_ADC_ADAPTIVE_STEP_EN
                step_log2_q[i] <= step_log2_d[i];
                run_q[i]       <= run_d[i];
`endif
            end
`ifdef TRACKING_ADC_ADAPTIVE_STEP_EN
            last_dir_q <= last_dir_d;
`endif
            uf_w_q      <= uf_w_d;
            of_w_q      <= of_w_d;
            win_q       <= win_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule
